// File: rtl/bellek.sv
// bellek: memory stage of the in-order core; loads/stores over a valid/ready data port.
// Optional misalignment trap enabled by defining BELLEK_HIZALAMA_DENETIM_EN.
`ifndef UOP_BIT
`define UOP_BIT 80
`endif
`ifndef VERI_BIT
`define VERI_BIT 32
`endif

module bellek (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  cek_bosalt_i,
    input  logic                  cek_duraklat_i,
    output logic                  duraklat_o,
    input  logic [`UOP_BIT-1:0]   bellek_uop_i,
    output logic                  istek_gecerli_o,
    input  logic                  istek_hazir_i,
    output logic                  istek_yaz_o,
    output logic [`VERI_BIT-1:0]  istek_adres_o,
    output logic [`VERI_BIT-1:0]  istek_veri_o,
    output logic [3:0]            istek_maske_o,
    input  logic                  yanit_gecerli_i,
    input  logic [`VERI_BIT-1:0]  yanit_veri_i,
    output logic                  hizalama_hata_o,
    output logic [`UOP_BIT-1:0]   geri_yaz_uop_o
);

    // Micro-op layout: {tag[79:69], bellek[68:65], rs2[64:33], rd[32:1], valid[0]}
    localparam int UOP_VALID  = 0;
    localparam int RD_LSB     = 1;
    localparam int RS2_LSB    = 33;
    localparam int BELLEK_LSB = 65;

    localparam logic [3:0] B_NOP = 4'd0;
    localparam logic [3:0] B_LB  = 4'd1;
    localparam logic [3:0] B_LH  = 4'd2;
    localparam logic [3:0] B_LW  = 4'd3;
    localparam logic [3:0] B_LBU = 4'd4;
    localparam logic [3:0] B_LHU = 4'd5;
    localparam logic [3:0] B_SB  = 4'd6;
    localparam logic [3:0] B_SH  = 4'd7;
    localparam logic [3:0] B_SW  = 4'd8;

    // state | meaning
    // BOSTA | idle; non-memory ops pass straight through
    // ISTEK | request on the bus, waiting for istek_hazir_i
    // BEKLE | load accepted, waiting for yanit_gecerli_i
    // TAMAM | result ready; written to geri_yaz_uop_o unless held downstream
    localparam logic [1:0] BOSTA = 2'd0;
    localparam logic [1:0] ISTEK = 2'd1;
    localparam logic [1:0] BEKLE = 2'd2;
    localparam logic [1:0] TAMAM = 2'd3;

    logic [1:0]           durum;
    logic                 iptal;
    logic [`UOP_BIT-1:0]  tut_uop;
    logic [1:0]           tut_a;
    logic [31:0]          sonuc;

    logic [3:0]           giris_islem;
    logic [31:0]          giris_adres;
    logic [31:0]          giris_rs2;
    logic                 bellek_op;
    logic                 giris_yaz;
    logic [1:0]           giris_boyut;
    logic [1:0]           a_etkin;
    logic [3:0]           giris_maske;
    logic [31:0]          giris_veri;

    logic [3:0]           tut_islem;
    logic [31:0]          kaydir;
    logic [31:0]          bicimli;
    logic [`UOP_BIT-1:0]  cikis_uop;

    always_comb begin
        giris_islem = bellek_uop_i[BELLEK_LSB +: 4];
        giris_adres = bellek_uop_i[RD_LSB +: 32];
        giris_rs2   = bellek_uop_i[RS2_LSB +: 32];
        bellek_op   = 1'b0;
        giris_yaz   = 1'b0;
        giris_boyut = 2'd0;
        case (giris_islem)
            B_LB, B_LBU: begin bellek_op = 1'b1; giris_boyut = 2'd0; end
            B_LH, B_LHU: begin bellek_op = 1'b1; giris_boyut = 2'd1; end
            B_LW:        begin bellek_op = 1'b1; giris_boyut = 2'd2; end
            B_SB:        begin bellek_op = 1'b1; giris_boyut = 2'd0; giris_yaz = 1'b1; end
            B_SH:        begin bellek_op = 1'b1; giris_boyut = 2'd1; giris_yaz = 1'b1; end
            B_SW:        begin bellek_op = 1'b1; giris_boyut = 2'd2; giris_yaz = 1'b1; end
            default:     bellek_op = 1'b0;
        endcase
        bellek_op = bellek_op & bellek_uop_i[UOP_VALID];

        // Offending low bits are dropped; with the trap enabled such ops never reach the bus.
        case (giris_boyut)
            2'd0:    begin a_etkin = giris_adres[1:0];          giris_maske = 4'b0001 << a_etkin; giris_veri = {4{giris_rs2[7:0]}};  end
            2'd1:    begin a_etkin = {giris_adres[1], 1'b0};    giris_maske = 4'b0011 << a_etkin; giris_veri = {2{giris_rs2[15:0]}}; end
            default: begin a_etkin = 2'b00;                     giris_maske = 4'hF;               giris_veri = giris_rs2;            end
        endcase
    end

`ifdef BELLEK_HIZALAMA_DENETIM_EN
    logic hizasiz;
    logic hata_r;
    assign hizasiz = ((giris_boyut == 2'd1) && giris_adres[0]) ||
                     ((giris_boyut == 2'd2) && (giris_adres[1:0] != 2'b00));
    assign hizalama_hata_o = hata_r;
`else
    assign hizalama_hata_o = 1'b0;
`endif

    always_comb begin
        tut_islem = tut_uop[BELLEK_LSB +: 4];
        kaydir    = yanit_veri_i >> {tut_a, 3'b000};
        case (tut_islem)
            B_LB:    bicimli = {{24{kaydir[7]}}, kaydir[7:0]};
            B_LBU:   bicimli = {24'd0, kaydir[7:0]};
            B_LH:    bicimli = {{16{kaydir[15]}}, kaydir[15:0]};
            B_LHU:   bicimli = {16'd0, kaydir[15:0]};
            default: bicimli = kaydir;
        endcase
        cikis_uop                  = tut_uop;
        cikis_uop[RD_LSB +: 32]    = sonuc;
        cikis_uop[UOP_VALID]       = ~iptal;
    end

    assign istek_gecerli_o = (durum == ISTEK);
    assign duraklat_o      = ((durum == BOSTA) && bellek_op) || (durum == ISTEK) ||
                             (durum == BEKLE) || cek_duraklat_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum          <= BOSTA;
            iptal          <= 1'b0;
            tut_uop        <= '0;
            tut_a          <= 2'b00;
            sonuc          <= '0;
            istek_yaz_o    <= 1'b0;
            istek_adres_o  <= '0;
            istek_veri_o   <= '0;
            istek_maske_o  <= 4'h0;
            geri_yaz_uop_o <= '0;
`ifdef BELLEK_HIZALAMA_DENETIM_EN
            hata_r         <= 1'b0;
`endif
        end else begin
`ifdef BELLEK_HIZALAMA_DENETIM_EN
            hata_r <= 1'b0;
`endif
            case (durum)
                BOSTA: begin
                    if (cek_bosalt_i) begin
                        geri_yaz_uop_o <= '0;
                    end else if (bellek_op) begin
                        tut_uop <= bellek_uop_i;
                        tut_a   <= a_etkin;
                        sonuc   <= '0;
`ifdef BELLEK_HIZALAMA_DENETIM_EN
                        if (hizasiz) begin
                            durum  <= TAMAM;
                            hata_r <= 1'b1;
                        end else begin
                            durum         <= ISTEK;
                            istek_yaz_o   <= giris_yaz;
                            istek_adres_o <= {giris_adres[31:2], 2'b00};
                            istek_veri_o  <= giris_yaz ? giris_veri : 32'd0;
                            istek_maske_o <= giris_maske;
                        end
`else
                        durum         <= ISTEK;
                        istek_yaz_o   <= giris_yaz;
                        istek_adres_o <= {giris_adres[31:2], 2'b00};
                        istek_veri_o  <= giris_yaz ? giris_veri : 32'd0;
                        istek_maske_o <= giris_maske;
`endif
                    end else if (!cek_duraklat_i) begin
                        geri_yaz_uop_o <= bellek_uop_i;
                    end
                end
                ISTEK: begin
                    if (cek_bosalt_i) iptal <= 1'b1;
                    if (istek_hazir_i) durum <= istek_yaz_o ? TAMAM : BEKLE;
                end
                BEKLE: begin
                    if (cek_bosalt_i) iptal <= 1'b1;
                    if (yanit_gecerli_i) begin
                        sonuc <= bicimli;
                        durum <= TAMAM;
                    end
                end
                default: begin
                    if (cek_bosalt_i) begin
                        geri_yaz_uop_o <= '0;
                        durum          <= BOSTA;
                        iptal          <= 1'b0;
                    end else if (!cek_duraklat_i) begin
                        geri_yaz_uop_o <= cikis_uop;
                        durum          <= BOSTA;
                        iptal          <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
